// File: rtl/my_if_rr_arbiter.sv
// Round-robin arbiter that shares one data/valid stream among NUM_REQ producers.
// Each grant holds for a burst ending on req_last or after MAX_BURST transferred beats.
module my_if_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q,    rr_d;
    logic [CW-1:0]   beat_q,  beat_d;

    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    int unsigned     scan_idx;

    logic            g_valid;
    logic            g_last;
    logic [DATA_W-1:0] g_data;
    logic            xfer;

    // Scan rr_q, rr_q+1, ... wrapping explicitly so non-power-of-two NUM_REQ works.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == grant_q) begin
                g_valid = req_valid[k];
                g_last  = req_last[k];
                g_data  = req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        out_valid = 1'b0;
        out_data  = '0;
        req_ready = '0;
        xfer      = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                out_valid          = g_valid;
                out_data           = g_data;
                req_ready[grant_q] = out_ready;
                xfer               = g_valid && out_ready;
                if (xfer) begin
                    if (g_last || (beat_q == CW'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        rr_d    = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                    end else begin
                        beat_d  = beat_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    assign busy     = (state_q == BURST);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_my_if_rr_arbiter.sv
// Bench for my_if_rr_arbiter: producers feed beat queues, a reference model predicts
// per-cycle outputs into a queue, and a monitor compares them against the DUT.
module tb_my_if_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        grant_id;
    logic              busy;

    my_if_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic [N-1:0]  rdy;
        logic          ov;
        logic [DW-1:0] d;
        int            g;
    } exp_t;

    exp_t        expq[$];
    logic [8:0]  srcq[N][$];   // {last, data}

    logic [N-1:0] en;
    logic         rdy_r;
    logic         rst_r;

    // Reference model: owner<0 means no grant; served counts beats of the current grant.
    int m_owner  = -1;
    int m_served = 0;
    int m_ptr    = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic cycle();
        exp_t         e;
        logic [N-1:0] seen;
        logic [8:0]   b;
        bit           found;
        int           idx;
        @(negedge clk);
        rst       = rst_r;
        out_ready = rdy_r;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && en[i]) begin
                b = srcq[i][0];
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = b[7:0];
                req_last[i]            = b[8];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = DW'($urandom);
                req_last[i]            = 1'($urandom);
            end
        end
        #1;
        e.busy = (m_owner >= 0);
        e.rdy  = '0;
        e.ov   = 1'b0;
        e.d    = '0;
        e.g    = 0;
        if (m_owner >= 0) begin
            e.ov           = req_valid[m_owner];
            e.d            = req_data[m_owner*DW +: DW];
            e.rdy[m_owner] = out_ready;
            e.g            = m_owner;
        end
        expq.push_back(e);
        seen = req_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && seen[i]) void'(srcq[i].pop_front());
        end
        if (rst) begin
            m_owner  = -1;
            m_ptr    = 0;
            m_served = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_served = 0;
        end else if (req_valid[m_owner] && out_ready) begin
            m_served++;
            if (req_last[m_owner] || m_served == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic reset_dut();
        for (int i = 0; i < N; i++) srcq[i].delete();
        en    = '1;
        rdy_r = 1'b1;
        rst_r = 1'b1;
        cycle();
        cycle();
        rst_r = 1'b0;
    endtask

    task automatic drain(input string nm, input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            cycle();
            c++;
        end
        total++;
        if (pending()) begin
            bad++;
            $display("FAIL %s drain timeout actual=pending required=empty", nm);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("busy",      32'(busy),      32'(e.busy));
                chk("req_ready", 32'(req_ready), 32'(e.rdy));
                chk("out_valid", 32'(out_valid), 32'(e.ov));
                chk("out_data",  32'(out_data),  32'(e.d));
                if (e.busy) chk("grant_id", 32'(grant_id), 32'(e.g));
            end
        end
    end

    initial begin : driver
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        en        = '1;
        rdy_r     = 1'b1;
        rst_r     = 1'b1;

        // single requester, then check the pointer moved past it
        reset_dut();
        @(negedge clk);
        #3;
        chk("reset_grant_id", 32'(grant_id), 32'd0);
        srcq[2].push_back(9'h010);
        srcq[2].push_back(9'h011);
        srcq[2].push_back(9'h112);
        drain("single", 20);
        srcq[0].push_back(9'h1A0);
        srcq[3].push_back(9'h1A3);
        drain("after_single", 20);
        repeat (2) cycle();

        // everyone requesting, one-beat bursts
        reset_dut();
        for (int i = 0; i < N; i++) srcq[i].push_back(9'h120 + 9'(i));
        srcq[0].push_back(9'h124);
        drain("all_req", 40);
        repeat (2) cycle();

        // long stream without last, split by the beat limit
        reset_dut();
        for (int k = 0; k < 10; k++) srcq[1].push_back(9'h030 + 9'(k));
        drain("max_burst", 60);
        repeat (3) cycle();

        // backpressure on beat 2
        reset_dut();
        srcq[0].push_back(9'h040);
        srcq[0].push_back(9'h041);
        srcq[0].push_back(9'h142);
        cycle();
        cycle();
        rdy_r = 1'b0;
        repeat (3) cycle();
        rdy_r = 1'b1;
        drain("backpressure", 20);
        repeat (2) cycle();

        // grantee drops valid while requester 3 waits
        reset_dut();
        for (int k = 0; k < 4; k++) srcq[0].push_back(((k == 3) ? 9'h100 : 9'h000) | 9'(8'h50 + k));
        srcq[3].push_back(9'h060);
        srcq[3].push_back(9'h161);
        cycle();
        cycle();
        en[0] = 1'b0;
        repeat (2) cycle();
        en[0] = 1'b1;
        drain("valid_drop", 30);
        repeat (2) cycle();

        // reset mid-burst, next arbitration scans from 0
        reset_dut();
        for (int k = 0; k < 4; k++) srcq[2].push_back(((k == 3) ? 9'h100 : 9'h000) | 9'(8'h70 + k));
        cycle();
        cycle();
        rst_r = 1'b1;
        cycle();
        rst_r = 1'b0;
        srcq[0].push_back(9'h180);
        drain("mid_reset", 30);
        repeat (2) cycle();

        // randomized traffic
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() < 6 && $urandom_range(0, 3) == 0)
                    srcq[i].push_back({1'($urandom_range(0, 2) == 0), 8'($urandom)});
                en[i] = ($urandom_range(0, 4) != 0);
            end
            rdy_r = ($urandom_range(0, 3) != 0);
            rst_r = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst_r = 1'b0;
        en    = '1;
        rdy_r = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) srcq[i].push_back(9'h1FF);
        end
        drain("random_tail", 400);

        @(negedge clk);
        @(negedge clk);
        #3;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left actual=%0d required=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
